// File: rtl/pb_debounce_en_pkg.sv
// Shared types for the pushbutton debouncer.
package db_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARM_PRESS = 2'd1,
    HELD      = 2'd2,
    ARM_REL   = 2'd3
  } db_state_t;

endpackage

// File: rtl/pb_debounce_en_if.sv
// Button-side signal bundle: raw input in, conditioned level and pulses out.
interface pb_debounce_en_if;
  logic btn_raw;
  logic btn_db;
  logic press_en;
  logic release_en;

  modport master (
    output btn_raw,
    input  btn_db,
    input  press_en,
    input  release_en
  );

  modport slave (
    input  btn_raw,
    output btn_db,
    output press_en,
    output release_en
  );
endinterface

// File: rtl/pb_debounce_en_sync2.sv
// Two-flop synchronizer, asynchronous active-high reset to 0.
module sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
    end
  end

  assign q_o = sync2_q;

endmodule

// File: rtl/pb_debounce_en.sv
// Pushbutton debouncer: synchronizes the raw button, requires DB_CYCLES stable
// cycles to accept a transition, and emits one-cycle press/release enables.
module pb_debounce_en
  import db_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = 16,
  parameter bit          BTN_ACT_LOW = 1'b0
) (
  input logic              clk,
  input logic              RST,
  pb_debounce_en_if.slave  bus
);

  localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic             btn_in;
  logic             btn_sync;
  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_db_q, btn_db_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  assign btn_in = bus.btn_raw ^ BTN_ACT_LOW;

  sync2 u_sync2 (
    .clk_i (clk),
    .rst_i (RST),
    .d_i   (btn_in),
    .q_o   (btn_sync)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_sync) begin
          state_d = ARM_PRESS;
          cnt_d   = CntOne;
        end else begin
          cnt_d = '0;
        end
      end
      ARM_PRESS: begin
        if (!btn_sync) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = HELD;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      HELD: begin
        if (!btn_sync) begin
          state_d = ARM_REL;
          cnt_d   = CntOne;
        end
      end
      ARM_REL: begin
        if (btn_sync) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Level follows the accepted state so it flips in the same cycle as the pulse.
    btn_db_d = (state_d == HELD) || (state_d == ARM_REL);
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      btn_db_q  <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      btn_db_q  <= btn_db_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign bus.btn_db     = btn_db_q;
  assign bus.press_en   = press_q;
  assign bus.release_en = release_q;

endmodule

// File: tb/tb_pb_debounce_en.sv
// Directed bench for pb_debounce_en with DB_CYCLES=4, both input polarities.
module tb_pb_debounce_en;
  import db_pkg::*;

  logic clk;
  logic RST;
  int   checks;
  int   errors;
  int   press_cnt;
  int   rel_cnt;
  bit   both_seen;

  pb_debounce_en_if bus ();
  pb_debounce_en_if bus_n ();

  pb_debounce_en #(.DB_CYCLES(4), .BTN_ACT_LOW(1'b0)) u_dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  pb_debounce_en #(.DB_CYCLES(4), .BTN_ACT_LOW(1'b1)) u_dut_n (
    .clk (clk),
    .RST (RST),
    .bus (bus_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then sample 1 time unit later and tally pulses of u_dut.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.press_en === 1'b1) press_cnt++;
    if (bus.release_en === 1'b1) rel_cnt++;
    if (bus.press_en === 1'b1 && bus.release_en === 1'b1) both_seen = 1'b1;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    press_cnt   = 0;
    rel_cnt     = 0;
    both_seen   = 1'b0;
    RST         = 1'b1;
    bus.btn_raw   = 1'b1;
    bus_n.btn_raw = 1'b1;

    // Reset held with button pressed: outputs stay 0.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_db", {31'd0, bus.btn_db}, 32'd0);
      check("rst_press", {31'd0, bus.press_en}, 32'd0);
      check("rst_release", {31'd0, bus.release_en}, 32'd0);
    end
    check("rst_cnt", {30'd0, u_dut.cnt_q}, 32'd0);
    RST = 1'b0;
    press_cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 5) check("post_rst_db_e5", {31'd0, bus.btn_db}, 32'd0);
      if (i == 6) begin
        check("post_rst_db_e6", {31'd0, bus.btn_db}, 32'd1);
        check("post_rst_press_e6", {31'd0, bus.press_en}, 32'd1);
      end
      if (i == 7) check("post_rst_press_e7", {31'd0, bus.press_en}, 32'd0);
    end
    check("post_rst_press_count", press_cnt, 32'd1);

    // Release from HELD.
    bus.btn_raw = 1'b0;
    rel_cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 5) begin
        check("rel_db_e5", {31'd0, bus.btn_db}, 32'd1);
        check("rel_pulse_e5", {31'd0, bus.release_en}, 32'd0);
      end
      if (i == 6) begin
        check("rel_db_e6", {31'd0, bus.btn_db}, 32'd0);
        check("rel_pulse_e6", {31'd0, bus.release_en}, 32'd1);
      end
      if (i == 7) check("rel_pulse_e7", {31'd0, bus.release_en}, 32'd0);
    end
    check("rel_count", rel_cnt, 32'd1);

    // Clean press held 20 cycles: one press_en, no release_en.
    bus.btn_raw = 1'b1;
    press_cnt = 0;
    rel_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 5) check("clean_db_e5", {31'd0, bus.btn_db}, 32'd0);
      if (i == 6) begin
        check("clean_db_e6", {31'd0, bus.btn_db}, 32'd1);
        check("clean_press_e6", {31'd0, bus.press_en}, 32'd1);
      end
    end
    check("clean_press_count", press_cnt, 32'd1);
    check("clean_rel_count", rel_cnt, 32'd0);

    // Two-cycle low glitch while HELD is rejected.
    bus.btn_raw = 1'b0;
    tick();
    tick();
    bus.btn_raw = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("glitch_rel_count", rel_cnt, 32'd0);
    check("glitch_db", {31'd0, bus.btn_db}, 32'd1);

    // Full release back to IDLE.
    bus.btn_raw = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("idle_rel_count", rel_cnt, 32'd1);
    check("idle_db", {31'd0, bus.btn_db}, 32'd0);

    // Bounce 1,0,1,1,0 then low: nothing accepted.
    press_cnt = 0;
    rel_cnt = 0;
    bus.btn_raw = 1'b1; tick();
    bus.btn_raw = 1'b0; tick();
    bus.btn_raw = 1'b1; tick();
    bus.btn_raw = 1'b1; tick();
    bus.btn_raw = 1'b0; tick();
    for (int i = 0; i < 10; i++) tick();
    check("bounce_press_count", press_cnt, 32'd0);
    check("bounce_rel_count", rel_cnt, 32'd0);
    check("bounce_db", {31'd0, bus.btn_db}, 32'd0);
    check("bounce_cnt", {30'd0, u_dut.cnt_q}, 32'd0);
    check("bounce_state", {30'd0, u_dut.state_q}, {30'd0, IDLE});

    // Bounce 1,0 then settle high: accepted 6 edges after the last rise.
    bus.btn_raw = 1'b1; tick();
    bus.btn_raw = 1'b0; tick();
    bus.btn_raw = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 5) check("settle_db_e5", {31'd0, bus.btn_db}, 32'd0);
      if (i == 6) begin
        check("settle_db_e6", {31'd0, bus.btn_db}, 32'd1);
        check("settle_press_e6", {31'd0, bus.press_en}, 32'd1);
      end
    end
    check("settle_press_count", press_cnt, 32'd1);
    bus.btn_raw = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("settle_rel_count", rel_cnt, 32'd1);

    // Reset asserted mid-count discards it without a pulse.
    press_cnt = 0;
    rel_cnt = 0;
    bus.btn_raw = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("mid_state", {30'd0, u_dut.state_q}, {30'd0, ARM_PRESS});
    check("mid_cnt", {30'd0, u_dut.cnt_q}, 32'd2);
    RST = 1'b1;
    #1;
    check("mid_rst_state", {30'd0, u_dut.state_q}, {30'd0, IDLE});
    check("mid_rst_cnt", {30'd0, u_dut.cnt_q}, 32'd0);
    bus.btn_raw = 1'b0;
    tick();
    RST = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("mid_press_count", press_cnt, 32'd0);
    check("mid_db", {31'd0, bus.btn_db}, 32'd0);

    // Active-low instance: raw 1->0 is a press.
    check("n_idle_db", {31'd0, bus_n.btn_db}, 32'd0);
    bus_n.btn_raw = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 5) check("n_press_e5", {31'd0, bus_n.press_en}, 32'd0);
      if (i == 6) begin
        check("n_press_e6", {31'd0, bus_n.press_en}, 32'd1);
        check("n_db_e6", {31'd0, bus_n.btn_db}, 32'd1);
      end
      if (i == 7) check("n_press_e7", {31'd0, bus_n.press_en}, 32'd0);
    end

    check("never_both_pulses", {31'd0, both_seen}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pb_debounce_en.md
Name: pb_debounce_en

Overview:
- Pushbutton conditioner that sits directly upstream of the enabled-flop datapath.
- Synchronizes a raw asynchronous button input and filters bounce with a stable-count FSM.
- Emits a single-cycle enable pulse on each debounced press, which drives the EN input of downstream d_en_ff registers.
- Also provides the debounced level and a release pulse for counters and other consumers.

Parameters:
DB_CYCLES, 16, consecutive synchronized-stable cycles needed to accept a transition (legal range 2..2^20)
CNT_W, $clog2(DB_CYCLES), stable-counter width (derived, not overridden)
BTN_ACT_LOW, 0, 1 = raw button is active-low and is inverted before synchronizing

Ports:
clk  input  1  system clock, all state on rising edge
RST  input  1  asynchronous active-high reset
btn_raw  input  1  raw, bouncy, asynchronous button
btn_db  output  1  debounced button level (1 = pressed)
press_en  output  1  one-cycle pulse on accepted press, feeds EN of downstream enabled flops
release_en  output  1  one-cycle pulse on accepted release

Behaviour:
- Reset
  - RST high forces immediately, asynchronously: both sync flops = 0 (inactive level after polarity fix), counter = 0, state = IDLE, btn_db = 0, press_en = 0, release_en = 0.
  - Reset mid-count discards the partial count. No pulse is produced on reset entry or exit.
- Input conditioning
  - btn_in = btn_raw XOR BTN_ACT_LOW.
  - Two-flop synchronizer: sync1 <= btn_in, btn_sync <= sync1.
  - Nothing downstream of sync1 samples btn_raw directly.
- States, with btn_db registered and equal to 1 in HELD and ARM_REL:
  - IDLE: btn_sync=1 -> ARM_PRESS with cnt=1. Otherwise stay, cnt=0.
  - ARM_PRESS: btn_sync=0 -> IDLE, cnt=0 (glitch rejected). btn_sync=1 and cnt==DB_CYCLES-1 -> HELD, cnt=0, press_en=1 for that one cycle. Otherwise cnt+1.
  - HELD: btn_sync=0 -> ARM_REL with cnt=1. Otherwise stay.
  - ARM_REL: btn_sync=1 -> HELD, cnt=0. btn_sync=0 and cnt==DB_CYCLES-1 -> IDLE, cnt=0, release_en=1 for one cycle. Otherwise cnt+1.
- Latency
  - If btn_raw changes before clock edge 1 and then stays stable, btn_db and the pulse update at edge 2+DB_CYCLES.
  - The pulse is high for exactly the first cycle btn_db holds its new value.
- Pulse rules
  - press_en and release_en are registered outputs and are never high together.
  - A pulse is never longer than one cycle.
  - A new pulse requires a full opposite transition to be accepted first; holding the button gives exactly one press_en.
- Counter rules
  - The counter never exceeds DB_CYCLES-1 and does not wrap. CNT_W must hold DB_CYCLES-1.
  - A bounce of any length shorter than DB_CYCLES cycles, in either direction, leaves btn_db unchanged and produces no pulse.
- Invalid states go to IDLE through the default branch.

Decomposition:
- Package db_pkg: state enum typedef db_state_t {IDLE, ARM_PRESS, HELD, ARM_REL}, 2-bit encoding.
- Sub-module sync2: a two-flop synchronizer with asynchronous active-high reset value 0. It is instantiated once, and the debouncer FSM and counter live in the top.

Test Plan (DB_CYCLES=4):
- Reset: assert RST with btn_raw=1 for 3 cycles, then release -> all outputs 0 during reset. After release, btn_db rises at edge 2+4 and press_en pulses once; no pulse is caused by reset itself.
- Clean press: btn_raw 0->1 before edge 1, held 20 cycles -> btn_db=1 at edge 6; press_en=1 only in cycle 6; release_en stays 0.
- Bounce reject: raw pattern 1,0,1,1,0 (one value per cycle), then 0 -> btn_db stays 0, no pulses, counter returns to 0.
- Bounce then settle: raw 1,0,1 then held 1 -> btn_db rises exactly 2+4 edges after the last 0->1 edge; exactly one press_en.
- Release: from HELD, raw 1->0 held -> release_en for one cycle at edge 6; btn_db=0 in the same cycle. A 2-cycle low glitch while HELD -> no release_en.
- Reset mid-count and polarity: RST pulsed during ARM_PRESS at cnt=2 -> state IDLE, no pulse. With BTN_ACT_LOW=1, raw 1->0 -> press_en after 2+4 edges.
